// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait/freeze with timeout, plus saturating stall/flush statistics.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           rn_ID,
  input  logic [4:0]           rm_ID,
  input  logic                 uses_rm_ID,
  input  logic                 MemRead_ID_EX,
  input  logic [4:0]           write_register_ID_EX,
  input  logic                 MemRead_EX_MEM,
  input  logic                 MemWrite_EX_MEM,
  input  logic                 or_out,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_bubble,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 freeze,
  output logic                 mem_req,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       mem_access;
  logic       load_use;
  logic       stall;
  logic       flush;
  logic       set_error;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    freeze        = 1'b0;
    mem_req       = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    set_error     = 1'b0;

    mem_access = MemRead_EX_MEM | MemWrite_EX_MEM;
    // X31 is the zero register, so a load targeting it never creates a hazard.
    load_use = MemRead_ID_EX && (write_register_ID_EX != 5'd31) &&
               ((write_register_ID_EX == rn_ID) ||
                (uses_rm_ID && (write_register_ID_EX == rm_ID)));

    if (!reset) begin
      unique case (state)
        RUN, FLUSH: begin
          mem_req = mem_access;
          if (mem_access && !mem_ready) begin
            freeze        = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            wait_cnt_next = 8'd0;
            state_next    = MEM_WAIT;
          end else if (state == FLUSH) begin
            state_next = RUN;
          end else if (or_out) begin
            flush        = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            state_next   = FLUSH;
          end else if (load_use) begin
            stall        = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            wait_cnt_next = 8'd0;
            state_next    = RUN;
          end else begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            // The final waiting cycle still freezes; the abort takes effect at its edge.
            if (wait_cnt == WAIT_LAST) begin
              set_error     = 1'b1;
              wait_cnt_next = 8'd0;
              state_next    = RUN;
            end else begin
              wait_cnt_next = wait_cnt + 8'd1;
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (set_error) mem_error <= 1'b1;
      if (!freeze) begin
        if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_WIDTH'(1);
        if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before abort (1..255).
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the stall and flush statistics counters.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rn_ID, input, 5: first source register of the instruction in ID (instruction_IF_ID[9:5]).
REQ-006 SHALL have port rm_ID, input, 5: second source register of the instruction in ID (Rm, or Rt when Reg2Loc).
REQ-007 SHALL have port uses_rm_ID, input, 1: the ID instruction reads rm_ID.
REQ-008 SHALL have port MemRead_ID_EX, input, 1: the EX-stage instruction is a load.
REQ-009 SHALL have port write_register_ID_EX, input, 5: destination register of the EX-stage instruction.
REQ-010 SHALL have port MemRead_EX_MEM, input, 1: the MEM-stage instruction reads data memory.
REQ-011 SHALL have port MemWrite_EX_MEM, input, 1: the MEM-stage instruction writes data memory.
REQ-012 SHALL have port or_out, input, 1: branch taken, resolved in MEM.
REQ-013 SHALL have port mem_ready, input, 1: data memory completed the current access.
REQ-014 SHALL have port pc_write, output, 1: PC may update.
REQ-015 SHALL have port if_id_write, output, 1: IF_ID may load.
REQ-016 SHALL have port id_ex_bubble, output, 1: load zeros into the ID_EX control fields.
REQ-017 SHALL have port flush_if_id, output, 1: clear IF_ID.
REQ-018 SHALL have port flush_id_ex, output, 1: clear ID_EX.
REQ-019 SHALL have port flush_ex_mem, output, 1: clear EX_MEM.
REQ-020 SHALL have port freeze, output, 1: hold every pipeline register and the PC.
REQ-021 SHALL have port mem_req, output, 1: data memory access request.
REQ-022 SHALL have port mem_error, output, 1: sticky flag; a memory timeout occurred.
REQ-023 SHALL have port stall_count, output, CNT_WIDTH: number of load-use stall cycles.
REQ-024 SHALL have port flush_count, output, CNT_WIDTH: number of taken-branch flushes.

Function
REQ-025 SHALL implement the FSM states RUN, MEM_WAIT and FLUSH, encoded in 2 bits.
REQ-026 SHALL evaluate mem_access = MemRead_EX_MEM | MemWrite_EX_MEM combinationally; mem_req = mem_access in RUN and FLUSH, and mem_req = 1 in MEM_WAIT.
REQ-027 SHALL detect load-use combinationally as: MemRead_ID_EX & write_register_ID_EX != 31 & (write_register_ID_EX == rn_ID | (uses_rm_ID & write_register_ID_EX == rm_ID)).
REQ-028 SHALL, in RUN with load-use, no or_out and no pending memory wait, drive pc_write=0, if_id_write=0 and id_ex_bubble=1 in the same cycle, and increment stall_count.
REQ-029 SHALL, in RUN with or_out=1, drive flush_if_id=1, flush_id_ex=1 and flush_ex_mem=1 in the same cycle, increment flush_count, and go to FLUSH.
REQ-030 SHALL give or_out priority over load-use, so that no stall is asserted in a flush cycle.
REQ-031 SHALL stay in FLUSH for exactly 1 cycle: load-use and or_out are ignored, pc_write=1 and if_id_write=1, then the FSM returns to RUN.
REQ-032 SHALL, in RUN or FLUSH with mem_access=1 and mem_ready=0, assert freeze=1, pc_write=0 and if_id_write=0 in that cycle, suppress the flush and stall outputs, and go to MEM_WAIT.
REQ-033 SHALL allow a taken branch and a memory wait to coincide: the memory wait wins, and or_out is re-sampled once the FSM is back in RUN.
REQ-034 SHALL, in MEM_WAIT, hold freeze=1 and increment an 8-bit wait counter; mem_ready=1 ends the wait: freeze=0 that cycle, the counter clears and the FSM returns to RUN.
REQ-035 SHALL, when the wait counter reaches MEM_TIMEOUT without mem_ready, set mem_error=1, clear the counter, drop freeze and return to RUN.
REQ-036 SHALL make mem_error sticky; only reset clears it.
REQ-037 SHALL let mem_access with mem_ready=1 in the same cycle complete with no freeze and no state change.
REQ-038 SHALL make stall_count and flush_count saturate at all ones and never wrap.
REQ-039 SHALL hold both counters while freeze=1.
REQ-040 SHALL, outside the cases above, drive pc_write=1 and if_id_write=1 and all other control outputs to 0.

Reset
REQ-041 SHALL, on a reset edge, go to RUN and clear the wait counter, mem_error, stall_count and flush_count.
REQ-042 SHALL, while reset=1, drive pc_write=1, if_id_write=1, freeze=0, mem_req=0, all flushes=0 and id_ex_bubble=0.
REQ-043 SHALL let reset asserted mid-MEM_WAIT or mid-FLUSH abort the operation at the next edge, with no mem_error set.

Verification
REQ-044 SHALL cover load-use: MemRead_ID_EX=1, write_register_ID_EX=3, rn_ID=3 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1.
REQ-045 SHALL cover X31 as a non-hazard: write_register_ID_EX=31=rm_ID, uses_rm_ID=1 -> no stall.
REQ-046 SHALL cover branch plus load-use in the same cycle: or_out=1 with a load-use -> all three flushes=1, no stall, FLUSH for 1 cycle, flush_count=1.
REQ-047 SHALL cover a memory wait: MemRead_EX_MEM=1, mem_ready low for 4 cycles -> freeze high for exactly 4 cycles, low on the mem_ready cycle.
REQ-048 SHALL cover timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_error=1 after 8 MEM_WAIT cycles, FSM back in RUN, mem_error stays 1 until reset.
REQ-049 SHALL cover reset mid-MEM_WAIT -> next cycle state RUN, freeze=0, counters=0.
